btn_debounce: RTL and testbench

- Input conditioner that sits directly upstream of the two-input combinational logic stage on the TinyFPGA board.
- Takes WIDTH raw, asynchronous push-button/switch levels and synchronises each one to clk.
- Debounces each channel with a per-channel stability counter.
- Outputs clean levels that drive in_1/in_0, plus a one-cycle press pulse per channel.

---
 rtl/board_pkg.sv | 11 +
 rtl/btn_debounce_ch.sv | 94 +++++++++
 rtl/btn_debounce.sv | 40 ++++
 tb/tb_btn_debounce.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Board-level constants shared by the TinyFPGA input path.
// Provides the system clock rate and the default debounce window in cycles.
package board_pkg;

  localparam int unsigned CLK_HZ      = 16000000;
  localparam int unsigned DEBOUNCE_MS = 10;

  // 10 ms at 16 MHz = 160000 cycles
  localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage : board_pkg

// File: rtl/btn_debounce_ch.sv
// Single-channel button conditioner: 2-flop synchroniser, stability counter,
// registered debounced level and one-cycle edge pulses.
// Optional macro BTN_DEBOUNCE_FALL_PULSE_EN enables the fall-pulse flop;
// without it fall_o is a constant 0.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_raw_i  raw pad level, asynchronous to clk
//   level_o    debounced level
//   rise_o     one-cycle pulse on level_o 0->1
//   fall_o     one-cycle pulse on level_o 1->0 (0 when feature disabled)
module btn_debounce_ch
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
  logic             fall_q, fall_d;
`endif

  // Counter runs only while the synchronised input disagrees with the
  // accepted level; any agreement restarts the window from zero.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
    fall_d  = 1'b0;
`endif
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
        fall_d  = ~sync2_q;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser and debounce state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
  // Fall pulse register, present only when the feature is built in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign fall_o = fall_q;
`else
  assign fall_o = 1'b0;
`endif

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule : btn_debounce_ch

// File: rtl/btn_debounce.sv
// WIDTH-channel push-button conditioner feeding the two-input logic stage.
// Each channel is synchronised, debounced and edge-detected independently.
// Optional macro BTN_DEBOUNCE_FALL_PULSE_EN enables btn_fall pulses;
// otherwise btn_fall is constant 0.
// Ports:
//   clk        system clock (16 MHz on board)
//   rst_n      asynchronous active-low reset
//   btn_raw    raw pad levels, may bounce
//   btn_level  debounced levels (drive in_1/in_0 downstream)
//   btn_rise   one-cycle pulse per channel on 0->1
//   btn_fall   one-cycle pulse per channel on 1->0
module btn_debounce
  import board_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall
);

  // One independent conditioner per channel
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw_i(btn_raw[g]),
      .level_o  (btn_level[g]),
      .rise_o   (btn_rise[g]),
      .fall_o   (btn_fall[g])
    );
  end

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES=4, WIDTH=2.
// Stimulus pushes expected output events (cycle, level, rise, fall); the
// monitor pops one whenever the outputs change or a pulse is present.
module tb_btn_debounce;

  localparam int unsigned N   = 4;
  localparam int          LAT = N + 2;
`ifdef BTN_DEBOUNCE_FALL_PULSE_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] btn_fall;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  bit   mon_done = 1'b0;
  logic [1:0] prev_level = '0;

  btn_debounce #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected event LAT edges after the first edge that samples the new input
  task automatic push_exp(input logic [1:0] lvl, input logic [1:0] rs, input logic [1:0] fl);
    exp_t e;
    e.cyc   = cyc + LAT;
    e.level = lvl;
    e.rise  = rs;
    e.fall  = FALL_EN ? fl : 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] lvl,
                       input logic [1:0] rs, input logic [1:0] fl);
    @(negedge clk);
    btn_raw = v;
    push_exp(lvl, rs, fl);
  endtask

  // Monitor: all comparisons happen here
  initial begin : monitor
    exp_t e;
    while (!mon_done) begin
      @(negedge clk or negedge rst_n);
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        mon_done = 1'b1;
      end else if (!rst_n) begin
        #1;
        checks++;
        if ({btn_level, btn_rise, btn_fall} != 6'b0) begin
          errors++;
          $display("FAIL reset_clear t=%0t level=%b rise=%b fall=%b want all 0",
                   $time, btn_level, btn_rise, btn_fall);
        end
        prev_level = '0;
      end else if (btn_rise != 2'b00 || btn_fall != 2'b00 || btn_level != prev_level) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event cyc=%0d level=%b rise=%b fall=%b",
                   cyc, btn_level, btn_rise, btn_fall);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL event_cycle got=%0d want=%0d", cyc, e.cyc);
          end
          checks++;
          if ({btn_level, btn_rise, btn_fall} != {e.level, e.rise, e.fall}) begin
            errors++;
            $display("FAIL event_value level=%b rise=%b fall=%b want level=%b rise=%b fall=%b",
                     btn_level, btn_rise, btn_fall, e.level, e.rise, e.fall);
          end
        end
        prev_level = btn_level;
      end
    end
  end

  // Stimulus
  initial begin : stim
    rst_n   = 1'b1;
    btn_raw = 2'b11;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);

    // Release reset with both inputs held high
    rst_n = 1'b1;
    push_exp(2'b11, 2'b11, 2'b00);
    repeat (10) @(negedge clk);

    // Both released
    drive(2'b00, 2'b00, 2'b00, 2'b11);
    repeat (10) @(negedge clk);

    // Clean press on ch0
    drive(2'b01, 2'b01, 2'b01, 2'b00);
    repeat (10) @(negedge clk);

    // Bounce on ch1: toggle every 2 cycles, final toggle leaves it high
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      btn_raw[1] = ~btn_raw[1];
      if (k < 10) @(negedge clk);
    end
    push_exp(2'b11, 2'b10, 2'b00);
    repeat (10) @(negedge clk);

    // Release ch0
    drive(2'b10, 2'b10, 2'b00, 2'b01);
    repeat (10) @(negedge clk);

    // Reset while ch0 counter sits at 2
    @(negedge clk);
    btn_raw = 2'b11;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(2'b11, 2'b11, 2'b00);
    repeat (10) @(negedge clk);

    // Simultaneous release then simultaneous press
    drive(2'b00, 2'b00, 2'b00, 2'b11);
    repeat (10) @(negedge clk);
    drive(2'b11, 2'b11, 2'b11, 2'b00);
    repeat (10) @(negedge clk);

    done = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
    if (!mon_done) begin
      errors++;
      $display("FAIL monitor_timeout got=0 want=1");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_btn_debounce
